// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcodes, control FSM states, ALU ops.
package cpu_pkg;

    localparam int unsigned OPCODE_W = 8;

    localparam logic [OPCODE_W-1:0] OP_NOP      = 8'h00;
    localparam logic [OPCODE_W-1:0] OP_LDAC     = 8'h01;
    localparam logic [OPCODE_W-1:0] OP_STAC     = 8'h02;
    localparam logic [OPCODE_W-1:0] OP_MVAC     = 8'h03;
    localparam logic [OPCODE_W-1:0] OP_MOVR     = 8'h04;
    localparam logic [OPCODE_W-1:0] OP_JUMP     = 8'h05;
    localparam logic [OPCODE_W-1:0] OP_JMPZ     = 8'h06;
    localparam logic [OPCODE_W-1:0] OP_JPNZ     = 8'h07;
    localparam logic [OPCODE_W-1:0] OP_ALU_BASE = 8'h08;

    typedef enum logic [3:0] {
        S_START,
        S_FETCH,
        S_DECODE,
        S_ADDR1,
        S_ADDR2,
        S_LD1,
        S_LD2,
        S_ST1,
        S_JMP,
        S_MVAC,
        S_MOVR,
        S_ALU,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_INAC,
        ALU_CLAC,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOT
    } alu_op_e;

    // ALU group occupies 0x08-0x0F; the low three bits select the operation.
    function automatic logic is_alu_op(input logic [OPCODE_W-1:0] op);
        return op[OPCODE_W-1:3] == OP_ALU_BASE[OPCODE_W-1:3];
    endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired Moore control FSM for the accumulator CPU; enables and selects decode from state.
module control_unit
    import cpu_pkg::*;
#(
    parameter bit ILLEGAL_HALTS = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instructionIn,
    input  logic       ACisZero,
    output logic       writeEnableAC,
    output logic       writeEnableR,
    output logic       writeEnableMem,
    output logic       PCEnable,
    output logic       instructionRegisterEnable,
    output logic       dataRegisterEnable,
    output logic       MSBaddressEnable,
    output logic       LSBaddressEnable,
    output logic       zeroEnable,
    output logic       muxSelectPC,
    output logic       muxSelectZero,
    output logic       muxSelectAddress,
    output logic       muxSelectALUtoAC,
    output logic       muxSelectMEM_or_R_toAC,
    output logic       illegalOpcode
);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   jump_taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_START;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    assign illegalOpcode = illegal_q;

    // IR is only reloaded in FETCH, so instructionIn is stable for the whole instruction.
    always_comb begin
        jump_taken = (instructionIn == OP_JUMP)
                   || ((instructionIn == OP_JMPZ) &&  ACisZero)
                   || ((instructionIn == OP_JPNZ) && !ACisZero);
    end

    always_comb begin
        state_d                   = state_q;
        illegal_d                 = illegal_q;
        writeEnableAC             = 1'b0;
        writeEnableR              = 1'b0;
        writeEnableMem            = 1'b0;
        PCEnable                  = 1'b0;
        instructionRegisterEnable = 1'b0;
        dataRegisterEnable        = 1'b0;
        MSBaddressEnable          = 1'b0;
        LSBaddressEnable          = 1'b0;
        zeroEnable                = 1'b0;
        muxSelectPC               = 1'b0;
        muxSelectZero             = 1'b0;
        muxSelectAddress          = 1'b0;
        muxSelectALUtoAC          = 1'b0;
        muxSelectMEM_or_R_toAC    = 1'b0;

        case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
                instructionRegisterEnable = 1'b1;
                PCEnable                  = 1'b1;
                state_d                   = S_DECODE;
            end
            S_DECODE: begin
                if (instructionIn == OP_NOP) begin
                    state_d = S_FETCH;
                end else if ((instructionIn == OP_LDAC) || (instructionIn == OP_STAC)
                          || (instructionIn == OP_JUMP) || (instructionIn == OP_JMPZ)
                          || (instructionIn == OP_JPNZ)) begin
                    state_d = S_ADDR1;
                end else if (instructionIn == OP_MVAC) begin
                    state_d = S_MVAC;
                end else if (instructionIn == OP_MOVR) begin
                    state_d = S_MOVR;
                end else if (is_alu_op(instructionIn)) begin
                    state_d = S_ALU;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ILLEGAL_HALTS ? S_HALT : S_FETCH;
                end
            end
            S_ADDR1: begin
                MSBaddressEnable = 1'b1;
                PCEnable         = 1'b1;
                state_d          = S_ADDR2;
            end
            S_ADDR2: begin
                LSBaddressEnable = 1'b1;
                PCEnable         = 1'b1;
                if (instructionIn == OP_LDAC) begin
                    state_d = S_LD1;
                end else if (instructionIn == OP_STAC) begin
                    state_d = S_ST1;
                end else begin
                    state_d = S_JMP;
                end
            end
            S_LD1: begin
                muxSelectAddress   = 1'b1;
                dataRegisterEnable = 1'b1;
                state_d            = S_LD2;
            end
            S_LD2: begin
                writeEnableAC          = 1'b1;
                muxSelectALUtoAC       = 1'b1;
                muxSelectMEM_or_R_toAC = 1'b1;
                zeroEnable             = 1'b1;
                muxSelectZero          = 1'b1;
                state_d                = S_FETCH;
            end
            S_ST1: begin
                muxSelectAddress = 1'b1;
                writeEnableMem   = 1'b1;
                state_d          = S_FETCH;
            end
            S_JMP: begin
                // Untaken branch leaves PC already past the two operand bytes.
                muxSelectPC = 1'b1;
                PCEnable    = jump_taken;
                state_d     = S_FETCH;
            end
            S_MVAC: begin
                writeEnableR = 1'b1;
                state_d      = S_FETCH;
            end
            S_MOVR: begin
                writeEnableAC    = 1'b1;
                muxSelectALUtoAC = 1'b1;
                zeroEnable       = 1'b1;
                muxSelectZero    = 1'b1;
                state_d          = S_FETCH;
            end
            S_ALU: begin
                writeEnableAC = 1'b1;
                zeroEnable    = 1'b1;
                state_d       = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_START;
        endcase
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired Moore FSM that sequences the 8-bit accumulator CPU datapath.
- Consumes the latched opcode and the Z flag from the datapath.
- Drives every register enable, memory write and mux select the datapath needs to run fetch, operand-address fetch and execute.
- Sits directly beside the datapath; the two together form the CPU core.

Parameters:
ILLEGAL_HALTS, 0, 1: an undefined opcode latches illegalOpcode and enters HALT until reset; 0: it executes as NOP and only latches illegalOpcode.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
instructionIn  input  8  opcode held in the datapath instruction register
ACisZero  input  1  Z flag register value
writeEnableAC  output  1  load AC
writeEnableR  output  1  load R from AC
writeEnableMem  output  1  write AC to M[addressIn]
PCEnable  output  1  load PC
instructionRegisterEnable  output  1  load IR from memory
dataRegisterEnable  output  1  load DR from memory
MSBaddressEnable  output  1  load address MSB from memory
LSBaddressEnable  output  1  load address LSB from memory
zeroEnable  output  1  load Z
muxSelectPC  output  1  0 = PC+1, 1 = {MSB,LSB}
muxSelectZero  output  1  0 = Z from ALU result, 1 = Z from AC write data
muxSelectAddress  output  1  0 = PC, 1 = {MSB,LSB}
muxSelectALUtoAC  output  1  0 = ALU result to AC, 1 = R/DR path to AC
muxSelectMEM_or_R_toAC  output  1  0 = R, 1 = DR
illegalOpcode  output  1  sticky flag, set on decode of an undefined opcode

Behaviour:
- Memory read is combinational; any register loaded from memory captures M[addressIn] at the same edge.
- Outputs are decoded from the state only, plus ACisZero in JMP. Any output not listed for a state is 0.
- Reset, asynchronous: state = START, illegalOpcode = 0. Every output is 0 while in START.
- START: no action; next state FETCH.
- FETCH: instructionRegisterEnable = 1, PCEnable = 1, selects 0 (IR <= M[PC], PC <= PC+1). Next state DECODE.
- DECODE: no enables. Dispatches on instructionIn:
  - 0x00 NOP: to FETCH.
  - 0x01 LDAC, 0x02 STAC, 0x05 JUMP, 0x06 JMPZ, 0x07 JPNZ: to ADDR1.
  - 0x03 MVAC: to MVAC.
  - 0x04 MOVR: to MOVR.
  - 0x08-0x0F (ALU op = instructionIn[2:0]): to ALU.
  - Anything else: set illegalOpcode, then go to HALT if ILLEGAL_HALTS else FETCH.
- ADDR1: MSBaddressEnable = 1, PCEnable = 1, muxSelectAddress = 0. Next state ADDR2.
- ADDR2: LSBaddressEnable = 1, PCEnable = 1. Next state: LD1 for LDAC, ST1 for STAC, else JMP.
- LD1: muxSelectAddress = 1, dataRegisterEnable = 1. Next state LD2.
- LD2: writeEnableAC = 1, muxSelectALUtoAC = 1, muxSelectMEM_or_R_toAC = 1, zeroEnable = 1, muxSelectZero = 1. Next state FETCH.
- ST1: muxSelectAddress = 1, writeEnableMem = 1. Next state FETCH.
- JMP: muxSelectPC = 1. PCEnable = 1 when any of these holds:
  - JUMP;
  - JMPZ and ACisZero = 1;
  - JPNZ and ACisZero = 0.
  Otherwise PC is left pointing past the operands. Next state FETCH.
- MVAC: writeEnableR = 1. Next state FETCH.
- MOVR: writeEnableAC = 1, muxSelectALUtoAC = 1, muxSelectMEM_or_R_toAC = 0, zeroEnable = 1, muxSelectZero = 1. Next state FETCH.
- ALU: writeEnableAC = 1, muxSelectALUtoAC = 0, zeroEnable = 1, muxSelectZero = 0. Next state FETCH.
- HALT: all outputs 0; stays in HALT until reset.
- Latency in cycles, FETCH to next FETCH: NOP 2, MVAC/MOVR/ALU 3, JUMP/JMPZ/JPNZ/STAC 5, LDAC 6.
- illegalOpcode stays set until reset. It is set again by each further illegal decode; there is no other clear.
- Reset asserted mid-instruction returns to START immediately. Partial operand loads are discarded.
- PC wraps 0xFFFF to 0x0000 inside the datapath; this block needs no special handling for it.
- ALU op codes, instructionIn[2:0]: 000 ADD, 001 SUB, 010 INAC, 011 CLAC, 100 AND, 101 OR, 110 XOR, 111 NOT.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams (OP_NOP .. OP_JPNZ, OP_ALU_BASE);
  - the state enum (START, FETCH, DECODE, ADDR1, ADDR2, LD1, LD2, ST1, JMP, MVAC, MOVR, ALU, HALT);
  - the ALU op enum.
- No sub-module: one state register plus next-state and output decode.

Test Plan:
1. Reset, then release → first rising edge in START with all outputs 0; FETCH on the following cycle with instructionRegisterEnable = 1 and PCEnable = 1.
2. Program 01 12 34 (LDAC 0x1234), M[0x1234] = 0x00 → 6-cycle sequence FETCH, DECODE, ADDR1, ADDR2, LD1, LD2; in LD2 writeEnableAC = 1, zeroEnable = 1, muxSelectZero = 1; AC = 0x00, Z = 1.
3. Opcode 0x06 with operands 0x20 0x00: ACisZero = 1 → PCEnable = 1 with muxSelectPC = 1 in JMP, PC = 0x2000. ACisZero = 0 → PCEnable = 0, PC = 0x0003.
4. Opcode 0x08 (ADD) with AC = 0xFF, R = 0x01 → ALU state with writeEnableAC = 1, zeroEnable = 1, muxSelectZero = 0; AC = 0x00, Z = 1; 3 cycles total.
5. Opcode 0x02 (STAC 0x00F0) → in ST1 writeEnableMem = 1 and muxSelectAddress = 1; M[0x00F0] = AC; no other enables asserted.
6. Opcode 0x42 → illegalOpcode = 1; with ILLEGAL_HALTS = 0, FETCH two cycles after the opcode fetch; with ILLEGAL_HALTS = 1, outputs stay 0 indefinitely. Assert reset during ADDR2 of a JUMP → START, illegalOpcode = 0, PC not loaded.
